round_countdown_timer: RTL and testbench
========================================

// Module: round_countdown_timer
// PURPOSE
//  Guessing-game round timer, directly downstream of the slow clock divider.
//  - Consumes the divider's toggling slow_in output; every toggle (rising or falling) is one game tick.
//  - Counts a loaded round time down to zero and flags round expiry to the game-control FSM.
//  - Exposes remaining ticks to the display path.
// PARAMETERS
//  W            8   width of load_val/time_left (max 255 ticks)
//  SYNC_STAGES  2   flops on slow_in before edge detect (>=2)
//  WARN_THRESH  5   warn asserts when 0 < time_left <= WARN_THRESH (ROUND_TIMER_WARN_EN only)
// PORTS
//  cin           in   1   system clock (50 MHz)
//  rst           in   1   asynchronous, active-high reset
//  slow_in       in   1   divider output; each level change = 1 tick
//  start         in   1   pulse: capture load_val, begin round
//  hold          in   1   level: freeze countdown while high
//  abort         in   1   pulse: cancel round, return to IDLE
//  load_val      in   W   round length in ticks, sampled on start
//  time_left     out  W   remaining ticks
//  running       out  1   high in RUN or PAUSE
//  timed_out     out  1   high in EXPIRED
//  expired_pulse out  1   one-cycle pulse on entry to EXPIRED
//  warn          out  1   low-time indicator (tied 0 when feature off)
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, time_left=0, running=0, timed_out=0, expired_pulse=0, warn=0,
//   sync flops=0, primed=0.
//  Tick gen: slow_in -> SYNC_STAGES flops -> one extra flop.
//   - tick = XOR(last two) & primed; tick is one cycle wide.
//   - primed sets once the sync chain has filled after reset (SYNC_STAGES+1 cycles).
//   - No spurious tick when slow_in=1 at reset release.
//   - slow_in edge -> time_left change: SYNC_STAGES+2 cin cycles.
//  FSM states: IDLE, RUN, PAUSE, EXPIRED.
//   Any state, abort=1      -> IDLE; time_left=0. abort beats start in the same cycle.
//   Any state, start=1, load_val!=0 -> RUN; time_left=load_val. Restart mid-round reloads.
//   Any state, start=1, load_val==0 -> EXPIRED; time_left=0; expired_pulse next cycle.
//   RUN, hold=1             -> PAUSE; a tick in this cycle is ignored.
//   RUN, tick, time_left>1  -> time_left-1.
//   RUN, tick, time_left==1 -> time_left=0; state EXPIRED.
//   PAUSE, hold=0           -> RUN. Ticks in PAUSE are dropped, not banked.
//   EXPIRED                 -> held until start or abort.
//  expired_pulse: registered; high exactly the first cycle the state is EXPIRED.
//  Arithmetic: time_left never decrements below 0 (no wrap). start has priority over tick.
//  Outputs are registered or decoded from the registered state; no combinational in->out path.
// CONFIGURATION
//  ROUND_TIMER_WARN_EN defined:
//   - warn is a registered flop: warn = running & (time_left!=0) & (time_left<=WARN_THRESH).
//  Not defined:
//   - warn=0 constantly; no comparator logic.
// STRUCTURE
//  guess_game_defs.vh (shared include):
//   - state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_EXPIRED (2-bit)
//   - default W and tick-width constants, reused by display and game-control FSMs
//  Sub-module toggle_tick_sync:
//   - synchronizer + toggle edge detect + primed flag
//   - params SYNC_STAGES; ports cin, rst, sig_in, tick
//  Top: FSM + down-counter + optional warn.
// TESTING
//  1 rst with slow_in=1, release, hold slow_in steady 20 cycles -> no tick; time_left=0; state IDLE.
//  2 start, load_val=3; toggle slow_in 3x, 10 cycles apart -> time_left 3,2,1,0;
//    expired_pulse high exactly 1 cycle; timed_out=1; running=0.
//  3 load_val=5, 1 tick, hold=1, 4 toggles, hold=0, 1 tick -> time_left=3 (paused ticks dropped).
//  4 start+abort same cycle with load_val=9 -> IDLE, time_left=0; start, load_val=0 -> timed_out=1
//    plus one expired_pulse.
//  5 mid-round, time_left=4: start with load_val=7 -> time_left=7, running=1.
//    Assert rst mid-round -> all outputs 0 immediately (async).
//  6 WARN_EN, WARN_THRESH=5, load_val=7 -> warn=0 at 7,6; warn=1 at 5..1; warn=0 at 0.
//    Without WARN_EN -> warn=0 throughout.

Source files
------------

// File: rtl/round_countdown_timer_pkg.sv
// Shared guessing-game definitions: FSM state encodings and default widths,
// also used by the display path and game-control FSMs.
package round_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam int DEF_W           = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_WARN_THRESH = 5;
    localparam int TICK_W          = 1;

    // A round is live (counting or paused) in these states.
    function automatic logic is_active(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/round_countdown_timer_toggle_tick_sync.sv
// Synchronises the divider's slow toggle and emits a registered one-cycle tick
// per level change; sig_in change -> tick high takes SYNC_STAGES+1 cycles.
module toggle_tick_sync
    import round_countdown_timer_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              cin,
    input  logic              rst,
    input  logic              sig_in,
    output logic [TICK_W-1:0] tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   primed;

    // primed rises only once last_q has caught up with a full chain, so a
    // high sig_in at reset release never reads as an edge.
    assign primed = fill_q[SYNC_STAGES];

    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
            fill_q <= '0;
            tick   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            last_q <= sync_q[SYNC_STAGES-1];
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            tick   <= TICK_W'((sync_q[SYNC_STAGES-1] ^ last_q) & primed);
        end
    end

endmodule

// File: rtl/round_countdown_timer.sv
// Round countdown: loads on start, decrements per slow tick, flags expiry; slow_in
// edge -> time_left update is SYNC_STAGES+2 cycles. Optional warn via ROUND_TIMER_WARN_EN.
module round_countdown_timer
    import round_countdown_timer_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef ROUND_TIMER_WARN_EN
    ,
    parameter int WARN_THRESH = DEF_WARN_THRESH
`endif
) (
    input  logic         cin,
    input  logic         rst,
    input  logic         slow_in,
    input  logic         start,
    input  logic         hold,
    input  logic         abort,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] time_left,
    output logic         running,
    output logic         timed_out,
    output logic         expired_pulse,
    output logic         warn
);

    state_t              state;
    state_t              state_nxt;
    logic [W-1:0]        tl_nxt;
    logic [TICK_W-1:0]   tick;

    toggle_tick_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .cin    (cin),
        .rst    (rst),
        .sig_in (slow_in),
        .tick   (tick)
    );

    // Priority: abort, then start, then hold, then tick.
    always_comb begin
        state_nxt = state;
        tl_nxt    = time_left;
        if (abort) begin
            state_nxt = ST_IDLE;
            tl_nxt    = '0;
        end else if (start) begin
            if (load_val != '0) begin
                state_nxt = ST_RUN;
                tl_nxt    = load_val;
            end else begin
                state_nxt = ST_EXPIRED;
                tl_nxt    = '0;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (hold) begin
                        state_nxt = ST_PAUSE;
                    end else if (tick[0]) begin
                        if (time_left > W'(1)) begin
                            tl_nxt = time_left - W'(1);
                        end else begin
                            tl_nxt    = '0;
                            state_nxt = ST_EXPIRED;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!hold) state_nxt = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            time_left     <= '0;
            expired_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            time_left     <= tl_nxt;
            expired_pulse <= (state_nxt == ST_EXPIRED) && (state != ST_EXPIRED);
        end
    end

    assign running   = is_active(state);
    assign timed_out = (state == ST_EXPIRED);

`ifdef ROUND_TIMER_WARN_EN
    // Computed from next-state values so warn lines up with time_left.
    always_ff @(posedge cin or posedge rst) begin
        if (rst) begin
            warn <= 1'b0;
        end else begin
            warn <= is_active(state_nxt) && (tl_nxt != '0) && (tl_nxt <= W'(WARN_THRESH));
        end
    end
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_round_countdown_timer.sv
// Directed bench for round_countdown_timer: reset, countdown, hold, abort, restart, warn.
module tb_round_countdown_timer;

    localparam int W = 8;

    logic         cin = 1'b0;
    logic         rst;
    logic         slow_in;
    logic         start;
    logic         hold;
    logic         abort;
    logic [W-1:0] load_val;
    logic [W-1:0] time_left;
    logic         running;
    logic         timed_out;
    logic         expired_pulse;
    logic         warn;

    int n_total = 0;
    int n_pass  = 0;

    always #5 cin = ~cin;

    round_countdown_timer #(
        .W          (W),
        .SYNC_STAGES(2)
    ) dut (
        .cin          (cin),
        .rst          (rst),
        .slow_in      (slow_in),
        .start        (start),
        .hold         (hold),
        .abort        (abort),
        .load_val     (load_val),
        .time_left    (time_left),
        .running      (running),
        .timed_out    (timed_out),
        .expired_pulse(expired_pulse),
        .warn         (warn)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge cin);
            #1;
        end
    endtask

    task automatic tick_wait(input int n);
        slow_in = ~slow_in;
        cyc(n);
    endtask

    task automatic pulse_start(input logic [W-1:0] v);
        load_val = v;
        start    = 1'b1;
        cyc(1);
        start    = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; slow_in = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0; load_val = '0;
        cyc(3);
        n_total++;
        if ({time_left, running, timed_out, expired_pulse, warn} !== '0)
            $display("FAIL reset_outputs: got tl=%0d run=%b to=%b ep=%b warn=%b, want all 0",
                     time_left, running, timed_out, expired_pulse, warn);
        else n_pass++;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (dut.u_sync.tick !== 1'b0 || time_left !== '0 || running !== 1'b0 || timed_out !== 1'b0)
                bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL idle_no_tick: %0d bad cycles, want 0", bad);
        else n_pass++;
        // Round started right at reset release must not see a spurious tick.
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        pulse_start(8'd3);
        cyc(20);
        n_total++;
        if (time_left !== 8'd3) $display("FAIL release_no_spurious: tl=%0d want 3", time_left);
        else n_pass++;
        do_abort();
    endtask

    task automatic test_countdown();
        int pulses;
        pulse_start(8'd3);
        n_total++;
        if (time_left !== 8'd3 || running !== 1'b1)
            $display("FAIL cd_load: tl=%0d run=%b want 3/1", time_left, running);
        else n_pass++;
        slow_in = ~slow_in;
        cyc(3);
        n_total++;
        if (time_left !== 8'd3) $display("FAIL cd_latency_early: tl=%0d want 3", time_left);
        else n_pass++;
        cyc(1);
        n_total++;
        if (time_left !== 8'd2) $display("FAIL cd_latency_4: tl=%0d want 2", time_left);
        else n_pass++;
        cyc(6);
        tick_wait(10);
        n_total++;
        if (time_left !== 8'd1) $display("FAIL cd_tick2: tl=%0d want 1", time_left);
        else n_pass++;
        slow_in = ~slow_in;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (expired_pulse === 1'b1) pulses++;
        end
        n_total++;
        if (time_left !== 8'd0 || timed_out !== 1'b1 || running !== 1'b0)
            $display("FAIL cd_expired: tl=%0d to=%b run=%b want 0/1/0", time_left, timed_out, running);
        else n_pass++;
        n_total++;
        if (pulses !== 1) $display("FAIL cd_pulse_count: %0d want 1", pulses);
        else n_pass++;
        do_abort();
    endtask

    task automatic test_hold();
        pulse_start(8'd5);
        tick_wait(10);
        n_total++;
        if (time_left !== 8'd4) $display("FAIL hold_pre: tl=%0d want 4", time_left);
        else n_pass++;
        hold = 1'b1;
        cyc(1);
        for (int i = 0; i < 4; i++) tick_wait(10);
        n_total++;
        if (time_left !== 8'd4 || running !== 1'b1 || timed_out !== 1'b0)
            $display("FAIL hold_frozen: tl=%0d run=%b to=%b want 4/1/0", time_left, running, timed_out);
        else n_pass++;
        hold = 1'b0;
        cyc(2);
        tick_wait(10);
        n_total++;
        if (time_left !== 8'd3) $display("FAIL hold_resume: tl=%0d want 3", time_left);
        else n_pass++;
        do_abort();
    endtask

    task automatic test_abort();
        load_val = 8'd9; start = 1'b1; abort = 1'b1;
        cyc(1);
        start = 1'b0; abort = 1'b0;
        n_total++;
        if (time_left !== 8'd0 || running !== 1'b0 || timed_out !== 1'b0)
            $display("FAIL abort_beats_start: tl=%0d run=%b to=%b want 0/0/0", time_left, running, timed_out);
        else n_pass++;
        pulse_start(8'd0);
        n_total++;
        if (timed_out !== 1'b1 || time_left !== 8'd0 || expired_pulse !== 1'b1 || running !== 1'b0)
            $display("FAIL zero_load: to=%b tl=%0d ep=%b run=%b want 1/0/1/0",
                     timed_out, time_left, expired_pulse, running);
        else n_pass++;
        cyc(1);
        n_total++;
        if (expired_pulse !== 1'b0 || timed_out !== 1'b1)
            $display("FAIL zero_load_hold: ep=%b to=%b want 0/1", expired_pulse, timed_out);
        else n_pass++;
        do_abort();
        n_total++;
        if (timed_out !== 1'b0 || running !== 1'b0)
            $display("FAIL abort_from_expired: to=%b run=%b want 0/0", timed_out, running);
        else n_pass++;
    endtask

    task automatic test_restart();
        pulse_start(8'd5);
        tick_wait(10);
        n_total++;
        if (time_left !== 8'd4) $display("FAIL restart_pre: tl=%0d want 4", time_left);
        else n_pass++;
        pulse_start(8'd7);
        n_total++;
        if (time_left !== 8'd7 || running !== 1'b1)
            $display("FAIL restart_reload: tl=%0d run=%b want 7/1", time_left, running);
        else n_pass++;
        tick_wait(10);
        n_total++;
        if (time_left !== 8'd6) $display("FAIL restart_count: tl=%0d want 6", time_left);
        else n_pass++;
        #3 rst = 1'b1;
        #1;
        n_total++;
        if ({time_left, running, timed_out, expired_pulse, warn} !== '0)
            $display("FAIL async_reset: tl=%0d run=%b to=%b ep=%b warn=%b want all 0",
                     time_left, running, timed_out, expired_pulse, warn);
        else n_pass++;
        cyc(1);
        rst = 1'b0;
        cyc(5);
    endtask

    task automatic test_warn();
        logic exp_warn;
        pulse_start(8'd7);
        n_total++;
        if (time_left !== 8'd7 || warn !== 1'b0)
            $display("FAIL warn_at_7: tl=%0d warn=%b want 7/0", time_left, warn);
        else n_pass++;
        for (int k = 6; k >= 0; k--) begin
            tick_wait(10);
`ifdef ROUND_TIMER_WARN_EN
            exp_warn = (k != 0) && (k <= 5);
`else
            exp_warn = 1'b0;
`endif
            n_total++;
            if (time_left !== W'(k) || warn !== exp_warn)
                $display("FAIL warn_at_%0d: tl=%0d warn=%b want %0d/%b", k, time_left, warn, k, exp_warn);
            else n_pass++;
        end
        do_abort();
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_hold();
        test_abort();
        test_restart();
        test_warn();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
